// File: rtl/lut_layer_scheduler.sv
// lut_layer_scheduler
//   Evaluates one sparse LogicNets layer by time-multiplexing every neuron
//   onto a single shared truth-table RAM, one neuron per clock.
//
// Optional build macro: LUT_SCHED_CFG_READBACK_EN
//   When defined, adds a table readback port (cfg_re / cfg_rvalid / cfg_rdata).
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   s_valid/s_ready     input vector handshake; s_data holds neuron i fan-in
//                       at [i*FAN_IN +: FAN_IN]
//   m_valid/m_ready     result handshake; m_data holds neuron i output
//                       at [i*OUT_BITS +: OUT_BITS]
//   cfg_we/addr/wdata   table write, addr = {neuron_idx, fanin_pattern}
//   cfg_err             one-cycle pulse when a cfg access is rejected
//   busy                high in any state other than IDLE
//   cfg_re/rvalid/rdata (readback build only) table read, data one cycle later
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | accept table writes (priority) or a new input vector
// RUN   | issue one RAM read per neuron, store previous read result
// DRAIN | store the last neuron's read result, raise m_valid
// OUT   | hold result until downstream takes it
module lut_layer_scheduler #(
  parameter int NUM_NEURONS = 32,
  parameter int FAN_IN      = 4,
  parameter int OUT_BITS    = 2,
  parameter int CFG_AW      = $clog2(NUM_NEURONS) + FAN_IN
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [NUM_NEURONS*FAN_IN-1:0]   s_data,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [NUM_NEURONS*OUT_BITS-1:0] m_data,
  input  logic                            cfg_we,
  input  logic [CFG_AW-1:0]               cfg_addr,
  input  logic [OUT_BITS-1:0]             cfg_wdata,
  output logic                            cfg_err,
`ifdef LUT_SCHED_CFG_READBACK_EN
  input  logic                            cfg_re,
  output logic                            cfg_rvalid,
  output logic [OUT_BITS-1:0]             cfg_rdata,
`endif
  output logic                            busy
);

  localparam int IDX_W = $clog2(NUM_NEURONS);
  localparam int DEPTH = 1 << CFG_AW;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t                            state_q, state_d;
  logic [IDX_W-1:0]                  idx_q, idx_d;
  logic [IDX_W-1:0]                  prev_idx;
  logic [NUM_NEURONS*FAN_IN-1:0]     in_q, in_d;
  logic [NUM_NEURONS*OUT_BITS-1:0]   out_q, out_d;
  logic                              m_valid_q, m_valid_d;
  logic                              cfg_err_q, cfg_err_d;

  // Shared table RAM: single address, write in IDLE, read in RUN (and
  // readback in IDLE). Contents are intentionally not reset.
  logic [OUT_BITS-1:0]               mem [DEPTH];
  logic [OUT_BITS-1:0]               ram_rdata_q;
  logic                              ram_we;
  logic                              ram_re;
  logic [CFG_AW-1:0]                 ram_addr;

`ifdef LUT_SCHED_CFG_READBACK_EN
  logic                              cfg_rvalid_q, cfg_rvalid_d;
`endif

  assign prev_idx = idx_q - 1'b1;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    in_d      = in_q;
    out_d     = out_q;
    m_valid_d = m_valid_q;
    cfg_err_d = 1'b0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = cfg_addr;
`ifdef LUT_SCHED_CFG_READBACK_EN
    cfg_rvalid_d = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (cfg_we) begin
          ram_we = 1'b1;
`ifdef LUT_SCHED_CFG_READBACK_EN
          // A read colliding with a write is refused; the write proceeds.
          if (cfg_re) cfg_err_d = 1'b1;
        end else if (cfg_re) begin
          ram_re       = 1'b1;
          cfg_rvalid_d = 1'b1;
`endif
        end else if (s_valid) begin
          in_d    = s_data;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        ram_re   = 1'b1;
        ram_addr = {idx_q, in_q[idx_q*FAN_IN +: FAN_IN]};
        // Read data lags the address by one cycle, so it belongs to idx-1.
        if (idx_q != '0) out_d[prev_idx*OUT_BITS +: OUT_BITS] = ram_rdata_q;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) state_d = S_DRAIN;
      end

      S_DRAIN: begin
        out_d[(NUM_NEURONS-1)*OUT_BITS +: OUT_BITS] = ram_rdata_q;
        m_valid_d = 1'b1;
        state_d   = S_OUT;
      end

      S_OUT: begin
        if (m_valid_q && m_ready) begin
          m_valid_d = 1'b0;
          state_d   = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (cfg_we && (state_q != S_IDLE)) cfg_err_d = 1'b1;
`ifdef LUT_SCHED_CFG_READBACK_EN
    if (cfg_re && (state_q != S_IDLE)) cfg_err_d = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      in_q      <= '0;
      out_q     <= '0;
      m_valid_q <= 1'b0;
      cfg_err_q <= 1'b0;
`ifdef LUT_SCHED_CFG_READBACK_EN
      cfg_rvalid_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      in_q      <= in_d;
      out_q     <= out_d;
      m_valid_q <= m_valid_d;
      cfg_err_q <= cfg_err_d;
`ifdef LUT_SCHED_CFG_READBACK_EN
      cfg_rvalid_q <= cfg_rvalid_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= cfg_wdata;
    if (ram_re) ram_rdata_q <= mem[ram_addr];
  end

`ifdef LUT_SCHED_CFG_READBACK_EN
  assign s_ready    = (state_q == S_IDLE) && !cfg_we && !cfg_re;
  assign cfg_rvalid = cfg_rvalid_q;
  assign cfg_rdata  = cfg_rvalid_q ? ram_rdata_q : '0;
`else
  assign s_ready    = (state_q == S_IDLE) && !cfg_we;
`endif

  assign busy    = (state_q != S_IDLE);
  assign m_valid = m_valid_q;
  assign m_data  = out_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_lut_layer_scheduler.sv
// Bench for lut_layer_scheduler: directed phases with random vectors,
// checked against a truth-table model indexed by {neuron, pattern}.
module tb_lut_layer_scheduler;

  localparam int N   = 32;
  localparam int FI  = 4;
  localparam int OB  = 2;
  localparam int AW  = 9;
  localparam int NE  = 1 << AW;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [N*FI-1:0] s_data = '0;
  logic            m_valid;
  logic            m_ready = 1'b0;
  logic [N*OB-1:0] m_data;
  logic            cfg_we = 1'b0;
  logic [AW-1:0]   cfg_addr = '0;
  logic [OB-1:0]   cfg_wdata = '0;
  logic            cfg_err;
  logic            busy;
`ifdef LUT_SCHED_CFG_READBACK_EN
  logic            cfg_re = 1'b0;
  logic            cfg_rvalid;
  logic [OB-1:0]   cfg_rdata;
`endif

  lut_layer_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_err   (cfg_err),
`ifdef LUT_SCHED_CFG_READBACK_EN
    .cfg_re    (cfg_re),
    .cfg_rvalid(cfg_rvalid),
    .cfg_rdata (cfg_rdata),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic [OB-1:0] tbl [NE];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected layer output: each neuron looks up its own truth table.
  function automatic logic [N*OB-1:0] model(input logic [N*FI-1:0] v);
    logic [N*OB-1:0] r;
    int p;
    r = '0;
    for (int n = 0; n < N; n++) begin
      p = int'(v[n*FI +: FI]);
      r[n*OB +: OB] = tbl[n*16 + p];
    end
    return r;
  endfunction

  function automatic logic [N*FI-1:0] rand_vec();
    logic [N*FI-1:0] v;
    for (int k = 0; k < 4; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic cfg_write(input int addr, input logic [OB-1:0] d);
    cfg_we = 1'b1;
    cfg_addr = AW'(addr);
    cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
    tbl[addr] = d;
  endtask

  // kind 0: (n+p)%4, kind 1: p[1:0]^p[3:2]
  task automatic load_table(input int kind);
    int n, p;
    for (int a = 0; a < NE; a++) begin
      n = a / 16;
      p = a % 16;
      if (kind == 0) cfg_write(a, OB'((n + p) % 4));
      else           cfg_write(a, OB'((p % 4) ^ (p / 4)));
    end
  endtask

  task automatic send(input logic [N*FI-1:0] v, output int t_hs, output bit ok);
    s_data = v;
    s_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (s_ready) ok = 1'b1;
      tick();
    end
    t_hs = cyc;
    s_valid = 1'b0;
  endtask

  task automatic wait_valid(output int t, output bit ok);
    ok = m_valid;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick();
      ok = m_valid;
    end
    t = cyc;
  endtask

  task automatic go_idle();
    for (int i = 0; i < 200 && busy; i++) tick();
    chk("reach_idle", busy, 1'b0);
  endtask

  logic [N*FI-1:0] v;
  logic [N*OB-1:0] exp_d;
  int  t_hs, t_v, t_prev, p3, pulses;
  bit  ok, seen;
  logic [OB-1:0] newv;

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_data", m_data, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cfg_err", cfg_err, 1'b0);
    chk("rst_s_ready", s_ready, 1'b1);
    rst_n = 1'b1;
    tick();
    chk("idle_s_ready", s_ready, 1'b1);

    // Phase 1: (n+p)%4 table, all-zero fan-in, latency N+1
    load_table(0);
    chk("cfg_no_err_idle", cfg_err, 1'b0);
    m_ready = 1'b1;  // ignored until m_valid
    send('0, t_hs, ok);
    chk("p1_handshake", ok, 1'b1);
    chk("p1_busy", busy, 1'b1);
    chk("p1_s_ready_run", s_ready, 1'b0);
    wait_valid(t_v, ok);
    chk("p1_valid_seen", ok, 1'b1);
    chk("p1_latency", t_v - t_hs, N + 1);
    exp_d = '0;
    for (int n = 0; n < N; n++) exp_d[n*OB +: OB] = OB'(n % 4);
    chk("p1_data", m_data, exp_d);
    chk("p1_model", m_data, model('0));
    tick();
    chk("p1_valid_drop", m_valid, 1'b0);
    go_idle();

    // Phase 2: XOR table, 10 random vectors with m_ready held high
    load_table(1);
    t_prev = 0;
    for (int i = 0; i < 10; i++) begin
      v = rand_vec();
      send(v, t_hs, ok);
      chk("p2_handshake", ok, 1'b1);
      wait_valid(t_v, ok);
      chk("p2_valid_seen", ok, 1'b1);
      chk("p2_latency", t_v - t_hs, N + 1);
      chk("p2_data", m_data, model(v));
      // OUT -> IDLE -> accept, then N+1 to the next result
      if (i > 0) chk("p2_gap", t_v - t_prev, N + 3);
      t_prev = t_v;
    end
    go_idle();

    // Phase 3: back-pressure for 20 cycles
    m_ready = 1'b0;
    v = rand_vec();
    send(v, t_hs, ok);
    wait_valid(t_v, ok);
    chk("p3_valid_seen", ok, 1'b1);
    exp_d = model(v);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("p3_hold_data", m_data, exp_d);
      chk("p3_hold_valid", m_valid, 1'b1);
      chk("p3_s_ready", s_ready, 1'b0);
      chk("p3_busy", busy, 1'b1);
    end
    m_ready = 1'b1;
    tick();
    chk("p3_after_valid", m_valid, 1'b0);
    chk("p3_after_s_ready", s_ready, 1'b1);
    chk("p3_after_data", m_data, exp_d);

    // Phase 4: write attempt during RUN is rejected
    v = rand_vec();
    send(v, t_hs, ok);
    repeat (5) tick();
    cfg_we = 1'b1;
    cfg_addr = '0;
    cfg_wdata = 2'b11;
    tick();
    cfg_we = 1'b0;
    chk("p4_err_pulse", cfg_err, 1'b1);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (cfg_err) pulses++;
    end
    chk("p4_err_once", pulses, 0);
    wait_valid(t_v, ok);
    chk("p4_latency", t_v - t_hs, N + 1);
    chk("p4_data", m_data, model(v));
    go_idle();
    send('0, t_hs, ok);
    wait_valid(t_v, ok);
    chk("p4_entry0_kept", m_data[OB-1:0], tbl[0]);
    chk("p4_zero_vec", m_data, model('0));
    go_idle();

    // Phase 5: write and vector in the same IDLE cycle; write wins
    v = rand_vec();
    p3 = int'(v[3*FI +: FI]);
    newv = ~tbl[3*16 + p3];
    s_data = v;
    s_valid = 1'b1;
    cfg_we = 1'b1;
    cfg_addr = AW'(3*16 + p3);
    cfg_wdata = newv;
    #1;
    chk("p5_s_ready_low", s_ready, 1'b0);
    tick();
    cfg_we = 1'b0;
    tbl[3*16 + p3] = newv;
    #1;
    chk("p5_still_idle", busy, 1'b0);
    chk("p5_s_ready_high", s_ready, 1'b1);
    send(v, t_hs, ok);
    wait_valid(t_v, ok);
    chk("p5_latency", t_v - t_hs, N + 1);
    chk("p5_new_entry", m_data[3*OB +: OB], newv);
    chk("p5_data", m_data, model(v));
    go_idle();

    // Phase 6: reset mid-RUN at idx 10
    v = rand_vec();
    send(v, t_hs, ok);
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    chk("p6_rst_busy", busy, 1'b0);
    chk("p6_rst_valid", m_valid, 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("p6_s_ready", s_ready, 1'b1);
    chk("p6_m_data_clr", m_data, '0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (m_valid || busy) seen = 1'b1;
    end
    chk("p6_no_result", seen, 1'b0);
    v = rand_vec();
    send(v, t_hs, ok);
    wait_valid(t_v, ok);
    chk("p6_valid_seen", ok, 1'b1);
    chk("p6_latency", t_v - t_hs, N + 1);
    chk("p6_table_kept", m_data, model(v));
    go_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
